// File: rtl/inv_mix_columns_iter_pkg.sv
// Shared AES model package.
// Holds the GF(2^8) reduction constant, state/matrix typedefs, the xtime
// helper and the FSM state type used by the iterative InvMixColumns engine.
package aes_model_pack;

  // Low byte of the AES reduction polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [7:0] MATH_ADDITIVE = 8'h1B;

  // 128-bit AES state; byte s[r][c] lives at bits [32*c+8*r +: 8].
  typedef logic [127:0] state_t;

  // Same state viewed as [col][row] bytes, so m[c] is one 32-bit column.
  typedef logic [3:0][3:0][7:0] byte_matrix_t;

  typedef logic [31:0] column_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } fsm_t;

  // Multiply by x in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? MATH_ADDITIVE : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_columns_iter_if.sv
// Handshake bundle for inv_mix_columns_iter.
//   in_valid/in_ready/in_state    : input state transfer
//   out_valid/out_ready/out_state : result transfer
// master = producer/consumer side, slave = the engine.
interface inv_mix_columns_iter_if;
  import aes_model_pack::*;

  logic   in_valid;
  logic   in_ready;
  state_t in_state;
  logic   out_valid;
  logic   out_ready;
  state_t out_state;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/inv_mix_columns_iter_one_column.sv
// inv_mix_one_column: combinational InvMixColumns of a single column.
//   col_in  : column bytes a0..a3 (a_r at bits [8*r +: 8])
//   col_out : b_r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3)
module inv_mix_one_column
  import aes_model_pack::*;
(
  input  column_t col_in,
  output column_t col_out
);

  logic [3:0][7:0] a;
  logic [3:0][7:0] x2, x4, x8;
  logic [3:0][7:0] m09, m0b, m0d, m0e;
  logic [3:0][7:0] b;

  assign a = col_in;

  for (genvar r = 0; r < 4; r++) begin : g_prod
    assign x2[r]  = xtime(a[r]);
    assign x4[r]  = xtime(x2[r]);
    assign x8[r]  = xtime(x4[r]);
    assign m09[r] = x8[r] ^ a[r];
    assign m0b[r] = x8[r] ^ x2[r] ^ a[r];
    assign m0d[r] = x8[r] ^ x4[r] ^ a[r];
    assign m0e[r] = x8[r] ^ x4[r] ^ x2[r];
  end

  assign b[0] = m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3];
  assign b[1] = m0e[1] ^ m0b[2] ^ m0d[3] ^ m09[0];
  assign b[2] = m0e[2] ^ m0b[3] ^ m0d[0] ^ m09[1];
  assign b[3] = m0e[3] ^ m0b[0] ^ m0d[1] ^ m09[2];

  assign col_out = b;

endmodule

// File: rtl/inv_mix_columns_iter.sv
// inv_mix_columns_iter: iterative AES InvMixColumns engine.
// Accepts one state, transforms COLS_PER_CYCLE columns per clock in place,
// then holds the result until the downstream handshake.
//   clk, rst : clock, synchronous active-high reset
//   bus      : in_valid/in_ready/in_state, out_valid/out_ready/out_state
//   busy     : high while columns are being transformed
module inv_mix_columns_iter
  import aes_model_pack::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  inv_mix_columns_iter_if.slave    bus,
  output logic                     busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
    $fatal(1, "inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);
  localparam logic [2:0] NCOL = 3'(COLS_PER_CYCLE);

  fsm_t           state;
  logic [1:0]     col;
  byte_matrix_t   work;
  byte_matrix_t   work_next;
  logic [3:0][31:0] mixed;

  // Lane g transforms column col+g; unused lanes read as zero.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    if (g < COLS_PER_CYCLE) begin : g_used
      logic [1:0] idx;
      assign idx = col + 2'(g);
      inv_mix_one_column u_col (
        .col_in  (work[idx]),
        .col_out (mixed[g])
      );
    end else begin : g_unused
      assign mixed[g] = '0;
    end
  end

  // Column c takes lane (c - col) when that lane is in the active group.
  for (genvar c = 0; c < 4; c++) begin : g_merge
    logic [1:0] off;
    assign off = 2'(c) - col;
    assign work_next[c] = ({1'b0, off} < NCOL) ? mixed[off] : work[c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      col           <= '0;
      work          <= '0;
      busy          <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_state <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            work         <= bus.in_state;
            col          <= '0;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= CALC;
          end
        end
        CALC: begin
          work <= work_next;
          if (col == LAST) begin
            col           <= '0;
            busy          <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_state <= work_next;
            state         <= DONE;
          end else begin
            col <= col + STEP;
          end
        end
        DONE: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Self-checking bench for inv_mix_columns_iter with COLS_PER_CYCLE = 1, 2, 4.
// Reference: generic GF(2^8) multiply and matrix products for forward and
// inverse MixColumns.
module tb_inv_mix_columns_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [2:0]   iv;
  logic [2:0]   orr;
  logic [127:0] ist;
  wire  [2:0]   ir;
  wire  [2:0]   ov;
  wire  [2:0]   bz;
  wire  [127:0] os [3];

  int ncmp = 0;
  int nfail = 0;

  inv_mix_columns_iter_if b0 ();
  inv_mix_columns_iter_if b1 ();
  inv_mix_columns_iter_if b2 ();

  assign b0.in_valid = iv[0];  assign b0.in_state = ist;  assign b0.out_ready = orr[0];
  assign b1.in_valid = iv[1];  assign b1.in_state = ist;  assign b1.out_ready = orr[1];
  assign b2.in_valid = iv[2];  assign b2.in_state = ist;  assign b2.out_ready = orr[2];
  assign ir[0] = b0.in_ready;  assign ov[0] = b0.out_valid;  assign os[0] = b0.out_state;
  assign ir[1] = b1.in_ready;  assign ov[1] = b1.out_valid;  assign os[1] = b1.out_state;
  assign ir[2] = b2.in_ready;  assign ov[2] = b2.out_valid;  assign os[2] = b2.out_state;

  inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) u0 (.clk(clk), .rst(rst), .bus(b0), .busy(bz[0]));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) u1 (.clk(clk), .rst(rst), .bus(b1), .busy(bz[1]));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) u2 (.clk(clk), .rst(rst), .bus(b2), .busy(bz[2]));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
    logic [7:0]   co [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (inv) co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     co = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(co[(k - row + 4) % 4], s[32*c + 8*k +: 8]);
        r[32*c + 8*row +: 8] = acc;
      end
    return r;
  endfunction

  // Columns written as r0..r3 from most significant byte down.
  function automatic logic [127:0] st4(input logic [31:0] c0, input logic [31:0] c1,
                                       input logic [31:0] c2, input logic [31:0] c3);
    logic [31:0]  w [4];
    logic [127:0] r;
    w = '{c0, c1, c2, c3};
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[32*c + 8*row +: 8] = w[c][31 - 8*row -: 8];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One transfer on DUT k; lat counts edges from accept to out_valid.
  task automatic run(input int k, input logic [127:0] st, output logic [127:0] res, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!ir[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 128'(ir[k]), 128'd1);
    ist = st;
    iv[k] = 1'b1;
    @(posedge clk);
    #1 iv[k] = 1'b0;
    lat = 0;
    while (!ov[k] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = os[k];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res, st, expv;
    int lat, n;
    int acc_t [$];

    rst = 1'b1; iv = '0; orr = '1; ist = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready", 128'(ir[k]), 128'd0);
      check("rst_out_valid", 128'(ov[k]), 128'd0);
      check("rst_busy", 128'(bz[k]), 128'd0);
      check("rst_out_state", os[k], 128'd0);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check("in_ready_after_rst", 128'(ir[k]), 128'd1);

    // Single column
    st = st4(32'h8e4da1bc, 32'h0, 32'h0, 32'h0);
    run(0, st, res, lat);
    check("single_col", res, st4(32'hdb135345, 32'h0, 32'h0, 32'h0));
    check("single_col_model", res, mix(st, 1'b1));
    check("single_col_lat", 128'(lat), 128'd4);

    // Full known state on all widths
    st = st4(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6);
    for (int k = 0; k < 3; k++) begin
      run(k, st, res, lat);
      check("full_state", res, st4(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5));
      check("full_state_lat", 128'(lat), 128'(4 >> k));
    end

    // Invariant states
    for (int k = 0; k < 3; k++) begin
      run(k, '0, res, lat);
      check("inv_zero", res, '0);
      run(k, '1, res, lat);
      check("inv_ones", res, '1);
      st = {4{32'h01010101}};
      run(k, st, res, lat);
      check("inv_0101", res, st);
    end

    // Backpressure in DONE
    orr[0] = 1'b0;
    st = rnd128();
    expv = mix(st, 1'b1);
    run(0, st, res, lat);
    check("bp_result", res, expv);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iv[0] = 1'b1;
      ist = rnd128();
      @(posedge clk);
      #1 iv[0] = 1'b0;
      check("bp_out_valid", 128'(ov[0]), 128'd1);
      check("bp_out_state", os[0], expv);
      check("bp_in_ready", 128'(ir[0]), 128'd0);
      check("bp_busy", 128'(bz[0]), 128'd0);
    end
    @(negedge clk) orr[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", 128'(ov[0]), 128'd0);
    check("bp_release_in_ready", 128'(ir[0]), 128'd1);
    check("bp_release_busy", 128'(bz[0]), 128'd0);
    check("bp_release_hold", os[0], expv);

    // Back-to-back throughput
    @(negedge clk);
    ist = rnd128();
    iv[0] = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (ir[0]) acc_t.push_back(cyc);
      @(negedge clk);
    end
    iv[0] = 1'b0;
    check("tput_count_ok", 128'(acc_t.size() >= 6), 128'd1);
    for (int i = 1; i < acc_t.size(); i++)
      check("tput_spacing", 128'(acc_t[i] - acc_t[i-1]), 128'd6);
    repeat (10) @(posedge clk);

    // Round trip through forward mix
    for (int i = 0; i < 200; i++) begin
      st = rnd128();
      run(0, mix(st, 1'b0), res, lat);
      check("round_trip", res, st);
    end
    for (int k = 1; k < 3; k++)
      for (int i = 0; i < 20; i++) begin
        st = rnd128();
        run(k, st, res, lat);
        check("rand_wide", res, mix(st, 1'b1));
        check("rand_wide_lat", 128'(lat), 128'(4 >> k));
      end

    // Reset at col=2 during CALC
    @(negedge clk);
    n = 0;
    while (!ir[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    ist = rnd128();
    iv[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("calc_busy", 128'(bz[0]), 128'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_calc_out_valid", 128'(ov[0]), 128'd0);
    check("rst_calc_busy", 128'(bz[0]), 128'd0);
    check("rst_calc_out_state", os[0], 128'd0);
    check("rst_calc_in_ready", 128'(ir[0]), 128'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_calc_ready_after", 128'(ir[0]), 128'd1);
    check("rst_calc_ov_after", 128'(ov[0]), 128'd0);

    // Reset while DONE is pending
    orr[0] = 1'b0;
    st = rnd128();
    run(0, st, res, lat);
    check("done_pending_result", res, mix(st, 1'b1));
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_done_out_valid", 128'(ov[0]), 128'd0);
    check("rst_done_busy", 128'(bz[0]), 128'd0);
    check("rst_done_out_state", os[0], 128'd0);
    @(negedge clk);
    rst = 1'b0;
    orr[0] = 1'b1;
    @(posedge clk);
    #1;
    check("rst_done_ready_after", 128'(ir[0]), 128'd1);
    st = {4{32'hc6c6c6c6}};
    run(0, st, res, lat);
    check("after_rst_c6", res, st);
    check("after_rst_c6_lat", 128'(lat), 128'd4);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/inv_mix_columns_iter.md
Name: inv_mix_columns_iter

Overview:
Iterative AES InvMixColumns engine for the decryption round path. It is the inverse of the forward column-mix used in encryption.
- Accepts one 128-bit state over a valid/ready handshake.
- Transforms the state COLS_PER_CYCLE columns per clock, multiplying each column by the fixed matrix [0e 0b 0d 09] (rows rotated) over GF(2^8).
- Presents the result on a valid/ready output until it is consumed.

Parameters:
- COLS_PER_CYCLE, 1: columns processed per clock. Legal values are 1, 2, 4; anything else is a fatal elaboration error.

Ports:
- clk, in, 1, system clock. Single clock domain.
- rst, in, 1, reset. Synchronous and active-high.
- in_valid, in, 1, input state valid.
- in_ready, out, 1, block can accept a state.
- in_state, in, 128, state; byte s[r][c] = in_state[32*c+8*r +: 8].
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts the result.
- out_state, out, 128, transformed state; same byte layout as in_state.
- busy, out, 1, high while in the CALC state.

Behaviour:
- Reset values (rst=1 at a rising edge): in_ready=0, out_valid=0, busy=0, out_state=0, column counter=0, FSM=IDLE.
  - in_ready rises on the cycle after rst deasserts.
  - rst has priority over every other event, including a mid-CALC or pending DONE. The in-flight state is discarded.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. When in_valid&&in_ready, register in_state into the work register, set col=0, go to CALC.
  - CALC: in_ready=0, busy=1. Each cycle, replace columns col..col+COLS_PER_CYCLE-1 in place with their InvMixColumns result, then col += COLS_PER_CYCLE.
  - Leaving CALC: when the last group has been written (col+COLS_PER_CYCLE==4), go to DONE.
  - DONE: out_valid=1 and out_state = work register, both held stable while out_ready=0. When out_valid&&out_ready, go to IDLE with out_valid=0.
- No overlap: in_ready is 0 in CALC and DONE, and a new accept happens at the earliest on the cycle after the output handshake.
- Latency: accept edge T gives out_valid high after edge T+4/COLS_PER_CYCLE, i.e. 4, 2 or 1 cycles.
  - Throughput: 1 state per (4/COLS_PER_CYCLE + 2) cycles when out_ready is tied high.
- out_state holds its last value in IDLE/CALC; consumers qualify it with out_valid only.
- in_valid while in_ready=0 is ignored; the source must hold its data.
- Column arithmetic: for column bytes a0..a3, output b_r = 0e·a_r ^ 0b·a_(r+1) ^ 0d·a_(r+2) ^ 09·a_(r+3), indices mod 4.
  - Products are built from xtime chains: x2=xtime(a), x4=xtime(x2), x8=xtime(x4). Then 09=x8^a, 0b=x8^x2^a, 0d=x8^x4^a, 0e=x8^x4^x2.
  - xtime(v) = (v<<1)[7:0] ^ (v[7] ? MATH_ADDITIVE : 0), with MATH_ADDITIVE = 8'h1B.
  - Purely combinational; no truncation beyond 8 bits.
- Column counter is 2 bits and wraps to 0 on CALC exit.

Decomposition:
- Shared package aes_model_pack holds:
  - MATH_ADDITIVE (existing constant, 8'h1B).
  - State typedef, byte-matrix typedef (packed [3:0][3:0][7:0], [col][row]).
  - xtime function.
  - A new fsm enum for IDLE/CALC/DONE.
- Sub-module inv_mix_one_column: combinational, 32-bit column in, 32-bit column out. Instantiate it COLS_PER_CYCLE times with a generate loop, muxing the columns by counter.

Test Plan:
- Single column, COLS_PER_CYCLE=1: column 0 = 8e 4d a1 bc, other columns 00 -> column 0 = db 13 53 45, others 00; out_valid exactly 4 cycles after accept.
- Full state with columns {8e4da1bc, 9fdc589d, 01010101, d5d5d7d6} (listed as r0..r3) -> {db135345, f20a225c, 01010101, d4d4d4d5}. Repeat for COLS_PER_CYCLE=2 and 4 with latency 2 and 1; results must be identical.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_state stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> one handshake, then in_ready=1 next cycle.
- Round trip: 200 random states passed through a reference forward MixColumns then this block -> bitwise equal to the originals. Back-to-back in_valid with out_ready=1 -> one accept every 6 cycles (COLS_PER_CYCLE=1).
- Reset mid-CALC (at col=2) and again in DONE -> next cycle out_valid=0, busy=0, out_state=0. in_ready=1 after rst drops, and the next state c6c6c6c6 x4 -> c6c6c6c6 x4.
- Invariant columns: all 00 -> 00; all ff -> ff; 01010101 x4 -> unchanged.
